// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle requests into fixed-length high levels
// separated by a guaranteed low gap, queueing requests that arrive while busy.
module pulse_stretcher #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in,
    input  logic              clr,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]     HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0]     GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0]     CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;
    logic              out_q, out_d;
    logic              last_s;
    logic              enq_s;
    logic              deq_s;
    logic              drop_s;

    assign last_s = (cnt_q == CNT_ZERO);

    // Next-state, counter reload and enqueue/dequeue decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enq_s   = 1'b0;
        deq_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in) begin
                    state_d = S_HIGH;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            S_HIGH: begin
                enq_s = in;
                if (last_s) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (last_s) begin
                    // A request on this edge with an empty queue starts directly
                    if ((pend_q != {PEND_W{1'b0}}) || in) begin
                        state_d = S_HIGH;
                        cnt_d   = HOLD_LD;
                        deq_s   = (pend_q != {PEND_W{1'b0}});
                        enq_s   = in && (pend_q != {PEND_W{1'b0}});
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    enq_s = in;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Pending counter with saturation and sticky overflow
    always_comb begin
        pend_d = pend_q;
        drop_s = 1'b0;
        if (enq_s && deq_s) begin
            pend_d = pend_q;
        end else if (enq_s) begin
            if (pend_q == PEND_MAX) begin
                drop_s = 1'b1;
            end else begin
                pend_d = pend_q + PEND_ONE;
            end
        end else if (deq_s) begin
            pend_d = pend_q - PEND_ONE;
        end else begin
            pend_d = pend_q;
        end
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        out_d = (state_d == S_HIGH);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            pend_q  <= {PEND_W{1'b0}};
            ovf_q   <= 1'b0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
        end
    end

    assign out      = out_q;
    assign busy     = (state_q != S_IDLE);
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random requests, checked
// against a burst-schedule model (start time of the current burst + queue size).
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PW   = 2;
    localparam int QMAX = 3;

    logic          clk;
    logic          reset;
    logic          in_s;
    logic          clr_s;
    logic          out_s;
    logic          busy_s;
    logic [PW-1:0] pend_s;
    logic          ovf_s;

    int total = 0;
    int bad   = 0;
    int t     = 0;

    // Model: whether a burst is in progress, the edge it started on, queue size
    int m_active = 0;
    int m_s      = 0;
    int m_q      = 0;
    int m_ovf    = 0;

    pulse_stretcher #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_W     (PW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in_s),
        .clr     (clr_s),
        .out     (out_s),
        .busy    (busy_s),
        .pending (pend_s),
        .overflow(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic model_edge(input logic i, input logic c);
        int set;
        set = 0;
        if (m_active != 0 && t == m_s + H + G) begin
            if (m_q > 0 || i) begin
                m_s = t;
                if (m_q > 0 && !i) m_q--;
            end else begin
                m_active = 0;
            end
        end else if (m_active == 0) begin
            if (i) begin
                m_active = 1;
                m_s = t;
            end
        end else if (i) begin
            if (m_q == QMAX) set = 1;
            else m_q++;
        end
        if (set != 0) m_ovf = 1;
        else if (c) m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e_out;
        e_out = (m_active != 0 && t < m_s + H) ? 8'd1 : 8'd0;
        check({tag, ".out"}, {7'd0, out_s}, e_out);
        check({tag, ".busy"}, {7'd0, busy_s}, 8'(m_active));
        check({tag, ".pending"}, {6'd0, pend_s}, 8'(m_q));
        check({tag, ".overflow"}, {7'd0, ovf_s}, 8'(m_ovf));
    endtask

    task automatic step(input string tag, input logic i, input logic c);
        in_s  = i;
        clr_s = c;
        @(posedge clk);
        t++;
        model_edge(i, c);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        in_s  = 1'b0;
        clr_s = 1'b0;
        #1;
        check_all("reset");
        #11;
        reset = 1'b0;

        // Single pulse
        step("single", 1'b1, 1'b0);
        repeat (8) step("single", 1'b0, 1'b0);

        // Three back-to-back requests
        repeat (3) step("held3", 1'b1, 1'b0);
        repeat (20) step("held3", 1'b0, 1'b0);

        // Saturation, clr colliding with a drop, then a plain clr
        repeat (4) step("ovf", 1'b1, 1'b0);
        step("ovf_clr_drop", 1'b1, 1'b1);
        check("ovf_sat_pending", {6'd0, pend_s}, 8'd3);
        check("ovf_sticky", {7'd0, ovf_s}, 8'd1);
        step("ovf_clr", 1'b0, 1'b1);
        check("ovf_cleared", {7'd0, ovf_s}, 8'd0);
        repeat (30) step("ovf_drain", 1'b0, 1'b0);

        // Request exactly on the GAP last-count edge, empty then non-empty queue
        step("bnd0", 1'b1, 1'b0);
        repeat (5) step("bnd0", 1'b0, 1'b0);
        step("bnd0_edge", 1'b1, 1'b0);
        check("bnd0_pending", {6'd0, pend_s}, 8'd0);
        repeat (12) step("bnd0_drain", 1'b0, 1'b0);
        repeat (2) step("bnd1", 1'b1, 1'b0);
        repeat (4) step("bnd1", 1'b0, 1'b0);
        step("bnd1_edge", 1'b1, 1'b0);
        check("bnd1_pending", {6'd0, pend_s}, 8'd1);
        repeat (20) step("bnd1_drain", 1'b0, 1'b0);

        // Asynchronous reset in the middle of a HIGH phase with two queued
        repeat (3) step("arst", 1'b1, 1'b0);
        in_s = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        m_active = 0;
        m_q      = 0;
        m_ovf    = 0;
        check("arst_out", {7'd0, out_s}, 8'd0);
        check("arst_busy", {7'd0, busy_s}, 8'd0);
        check("arst_pending", {6'd0, pend_s}, 8'd0);
        @(posedge clk);
        t++;
        #2;
        reset = 1'b0;
        step("post_rst", 1'b1, 1'b0);
        repeat (10) step("post_rst", 1'b0, 1'b0);

        // Random requests and clears
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 8));
        end
        repeat (30) step("rand_drain", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
